// File: rtl/count_seq_pkg.sv
// Shared state encoding and mode constants for the count sequencer.
package count_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/updown_step_counter.sv
// WIDTH-bit up/down counter register with load and step enable.
module updown_step_counter
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven sequencer: steps an up/down counter once-up, once-down or ping-pong
// between captured bounds at a prescaled rate, with done/err pulses.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic [DIV_W-1:0]  div,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state;
    logic [1:0]        mode_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  hi_q;
    logic [PASS_W-1:0] rem_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  presc_q;

    logic              cnt_load;
    logic [WIDTH-1:0]  cnt_load_val;
    logic              step;
    logic [WIDTH-1:0]  next_val;
    logic              at_end;

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = lo;
        if (state == StIdle && start && lo <= hi) begin
            cnt_load     = 1'b1;
            cnt_load_val = (mode == MODE_DOWN) ? hi : lo;
        end
    end

    // abort takes priority over a step due in the same cycle
    assign step     = (state == StRun) && !abort && (presc_q == div_q);
    assign next_val = dir ? count + WIDTH'(1) : count - WIDTH'(1);
    assign at_end   = dir ? (next_val == hi_q) : (next_val == lo_q);

    updown_step_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (step),
        .up_down  (dir),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= StIdle;
            dir     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            presc_q <= '0;
            mode_q  <= MODE_UP;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (lo > hi) begin
                            err <= 1'b1;
                        end else if (lo == hi) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            lo_q    <= lo;
                            hi_q    <= hi;
                            div_q   <= div;
                            rem_q   <= (passes == '0) ? PASS_W'(1) : passes;
                            presc_q <= '0;
                            dir     <= (mode != MODE_DOWN);
                            busy    <= 1'b1;
                            state   <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (presc_q == div_q) begin
                        presc_q <= '0;
                        if (at_end) begin
                            if (mode_q == MODE_PINGPONG) begin
                                dir   <= ~dir;
                                rem_q <= rem_q - PASS_W'(1);
                                if (rem_q == PASS_W'(1)) begin
                                    state <= StDone;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                state <= StDone;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        presc_q <= presc_q + DIV_W'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer using immediate assertions.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] passes;
    logic [7:0] div;
    logic [3:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    count_sequencer #(
        .WIDTH  (4),
        .DIV_W  (8),
        .PASS_W (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .mode   (mode),
        .lo     (lo),
        .hi     (hi),
        .passes (passes),
        .div    (div),
        .count  (count),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic b, input logic d, input logic e);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".err"}, 32'(err), 32'(e));
    endtask

    logic [3:0] pp_cnt [7] = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4};
    logic       pp_dir [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00;
        lo = '0; hi = '0; passes = '0; div = '0;

        // Reset state
        tick();
        tick();
        check("rst.count", 32'(count), 32'd0);
        check("rst.dir", 32'(dir), 32'd1);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // 1: up-once 3..7, div=0
        mode = 2'b00; lo = 4'd3; hi = 4'd7; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("up.start.count", 32'(count), 32'd3);
        check_flags("up.start", 1'b1, 1'b0, 1'b0);
        for (int i = 4; i <= 7; i++) begin
            tick();
            check($sformatf("up.count%0d", i), 32'(count), 32'(i));
            check($sformatf("up.busy%0d", i), 32'(busy), 32'(i < 7));
            check($sformatf("up.done%0d", i), 32'(done), 32'(i == 7));
        end
        tick();
        check("up.after.count", 32'(count), 32'd7);
        check_flags("up.after", 1'b0, 1'b0, 1'b0);

        // 2: ping-pong 2..4, passes=3, div=1
        mode = 2'b10; lo = 4'd2; hi = 4'd4; passes = 4'd3; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("pp.count%0d", k), 32'(count), 32'(pp_cnt[k]));
            check($sformatf("pp.dir%0d", k), 32'(dir), 32'(pp_dir[k]));
            check($sformatf("pp.done%0d", k), 32'(done), 32'(k == 6));
            if (k < 6) begin
                tick();
                check($sformatf("pp.hold%0d", k), 32'(count), 32'(pp_cnt[k]));
                tick();
            end
        end
        tick();
        check("pp.after.done", 32'(done), 32'd0);
        check("pp.after.count", 32'(count), 32'd4);

        // 3: down-once 5..1, div=2
        mode = 2'b01; lo = 4'd1; hi = 4'd5; div = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("dn.start.count", 32'(count), 32'd5);
        check("dn.start.dir", 32'(dir), 32'd0);
        for (int v = 4; v >= 1; v--) begin
            tick();
            tick();
            check($sformatf("dn.hold%0d", v), 32'(count), 32'(v + 1));
            tick();
            check($sformatf("dn.count%0d", v), 32'(count), 32'(v));
        end
        check_flags("dn.end", 1'b0, 1'b1, 1'b0);
        check("dn.end.dir", 32'(dir), 32'd0);

        // 4: rejected start, then lo==hi
        tick();
        mode = 2'b00; lo = 4'd9; hi = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check_flags("rej", 1'b0, 1'b0, 1'b1);
        check("rej.count", 32'(count), 32'd1);
        tick();
        check("rej.after.err", 32'(err), 32'd0);
        lo = 4'd6; hi = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        check("eq.count", 32'(count), 32'd6);
        check_flags("eq", 1'b0, 1'b1, 1'b0);
        tick();
        check_flags("eq.after", 1'b0, 1'b0, 1'b0);
        check("eq.after.count", 32'(count), 32'd6);

        // 5: abort with simultaneous start while running at count=5
        mode = 2'b00; lo = 4'd5; hi = 4'd9; div = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ab.run.count", 32'(count), 32'd5);
        check("ab.run.busy", 32'(busy), 32'd1);
        abort = 1'b1; start = 1'b1; lo = 4'd1; hi = 4'd3;
        tick();
        abort = 1'b0; start = 1'b0;
        check("ab.count", 32'(count), 32'd5);
        check_flags("ab", 1'b0, 1'b0, 1'b0);
        tick();
        check("ab.after.count", 32'(count), 32'd5);
        check_flags("ab.after", 1'b0, 1'b0, 1'b0);

        // 6: reset mid ping-pong, start held through reset
        mode = 2'b10; lo = 4'd2; hi = 4'd4; passes = 4'd2; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rr.pre.count", 32'(count), 32'd4);
        check("rr.pre.dir", 32'(dir), 32'd0);
        reset = 1'b1; start = 1'b1;
        tick();
        check("rr.count", 32'(count), 32'd0);
        check("rr.dir", 32'(dir), 32'd1);
        check_flags("rr", 1'b0, 1'b0, 1'b0);
        tick();
        check("rr.hold.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        start = 1'b0;
        check("rr.acc.count", 32'(count), 32'd2);
        check("rr.acc.busy", 32'(busy), 32'd1);
        check("rr.acc.dir", 32'(dir), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
